add64_seq_ctrl: RTL and testbench

ADD64_SEQ_CTRL -- requirements
Module: add64_seq_ctrl

---
 rtl/add64_pkg.sv | 40 ++++
 rtl/csa_slice16.sv | 30 +++
 rtl/add64_seq_ctrl.sv | 111 +++++++++++
 tb/tb_add64_seq_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/add64_pkg.sv
// rtl/add64_pkg.sv - shared constants, state type and ripple helper for the sequential 64-bit adder
//
// Purpose: common definitions for add64_seq_ctrl and csa_slice16.
// Contents:
//   DATA_W, SLICE_W, NUM_SLICES, IDX_W, LAST_IDX - datapath geometry
//   state_t                                      - controller states IDLE, RUN, DONE
//   ripple_add()                                 - bit-serial ripple adder returning {carry, sum}

package add64_pkg;

  localparam int DATA_W     = 64;
  localparam int SLICE_W    = 16;
  localparam int NUM_SLICES = DATA_W / SLICE_W;
  localparam int IDX_W      = 2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic [SLICE_W:0] ripple_add(
    input logic [SLICE_W-1:0] x,
    input logic [SLICE_W-1:0] y,
    input logic               c
  );
    logic [SLICE_W-1:0] s;
    logic               cy;
    s  = '0;
    cy = c;
    for (int i = 0; i < SLICE_W; i++) begin
      s[i] = x[i] ^ y[i] ^ cy;
      cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
    end
    return {cy, s};
  endfunction

endpackage

// File: rtl/csa_slice16.sv
// rtl/csa_slice16.sv - combinational 16-bit carry-select adder slice
//
// Purpose: adds one 16-bit slice for both possible carry-ins at once and
// picks the result with the late-arriving carry, so the carry only sees a mux.
// Ports:
//   a, b     in  [SLICE_W-1:0]  slice operands
//   sel_cin  in  1              carry into this slice (selects precomputed result)
//   s        out [SLICE_W-1:0]  selected slice sum
//   co       out 1              selected slice carry-out

module csa_slice16
  import add64_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               sel_cin,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W:0] res_c0;
  logic [SLICE_W:0] res_c1;

  // Two identical ripple adders, one per assumed carry-in.
  assign res_c0 = ripple_add(a, b, 1'b0);
  assign res_c1 = ripple_add(a, b, 1'b1);

  assign {co, s} = sel_cin ? res_c1 : res_c0;

endmodule

// File: rtl/add64_seq_ctrl.sv
// rtl/add64_seq_ctrl.sv - sequential 64-bit adder processing one 16-bit slice per cycle
//
// Purpose: on an accepted start, captures the operands and walks four
// carry-select slices from LSB to MSB, one per clock, then pulses done.
// Ports:
//   clk    in   1   clock, rising edge
//   rst_n  in   1   synchronous active-low reset
//   start  in   1   request an add; only honoured in IDLE
//   a, b   in   64  operands, captured on accepted start
//   cin    in   1   carry-in, captured on accepted start
//   busy   out  1   high while slices are being computed
//   done   out  1   one-cycle pulse when sum/cout are final
//   sum    out  64  result, held until the next accepted start
//   cout   out  1   final carry-out, held until the next accepted start

module add64_seq_ctrl
  import add64_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic               carry_r;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_co;

  // Slice operands come from the captured copies, so input changes
  // after start cannot disturb an add in flight.
  assign slice_a = op_a[int'(idx) * SLICE_W +: SLICE_W];
  assign slice_b = op_b[int'(idx) * SLICE_W +: SLICE_W];

  csa_slice16 u_slice (
    .a       (slice_a),
    .b       (slice_b),
    .sel_cin (carry_r),
    .s       (slice_s),
    .co      (slice_co)
  );

  // busy/done are registered alongside the state transition so they
  // always reflect the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      carry_r <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_a    <= a;
            op_b    <= b;
            carry_r <= cin;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            state   <= RUN;
            busy    <= 1'b1;
          end
        end

        RUN: begin
          sum[int'(idx) * SLICE_W +: SLICE_W] <= slice_s;
          carry_r <= slice_co;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            cout  <= slice_co;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add64_seq_ctrl.sv
// tb/tb_add64_seq_ctrl.sv - self-checking bench for add64_seq_ctrl

module tb_add64_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        cin = 1'b0;
  logic        busy;
  logic        done;
  logic [63:0] sum;
  logic        cout;

  int total = 0;
  int bad = 0;

  add64_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model: m_age counts rising edges since the last accepted start.
  // 0..3 computing, 4 done cycle, 5 and above idle (ready for start).
  localparam int IDLE_AGE = 5;
  int          m_age;
  logic [64:0] m_res;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_age <= IDLE_AGE;
      m_res <= '0;
    end else if (m_age >= IDLE_AGE && start) begin
      m_age <= 0;
      m_res <= {1'b0, a} + {1'b0, b} + 65'(cin);
    end else if (m_age < IDLE_AGE) begin
      m_age <= m_age + 1;
    end
  end

  logic [63:0] e_sum;
  logic        e_cout;

  always @(negedge clk) begin
    if (chk_en) begin
      // Slices land LSB first: after t slice edges the low 16*t bits are final.
      if (m_age == 0)
        e_sum = '0;
      else if (m_age < 4)
        e_sum = m_res[63:0] & ((64'd1 << (16 * m_age)) - 64'd1);
      else
        e_sum = m_res[63:0];
      e_cout = (m_age >= 4) ? m_res[64] : 1'b0;
      check("cyc_busy", 65'(busy), 65'(m_age <= 3));
      check("cyc_done", 65'(done), 65'(m_age == 4));
      check("cyc_sum", {1'b0, sum}, {1'b0, e_sum});
      check("cyc_cout", 65'(cout), 65'(e_cout));
    end
  end

  task automatic run_add(input logic [63:0] x, input logic [63:0] y, input logic c,
                         input logic [63:0] es, input logic ec, input string nm);
    int lat;
    int nb;
    bit seen;
    @(posedge clk); #1;
    a = x; b = y; cin = c; start = 1'b1;
    @(negedge clk);
    lat = 0; nb = 0; seen = 1'b0;
    while (!seen && lat < 30) begin
      @(posedge clk); #1;
      start = 1'b0;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      cin = 1'($urandom);
      @(negedge clk);
      lat++;
      if (busy) nb++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: no done after %0d cycles, want 5", nm, lat);
    end else begin
      check({nm, "_sum"}, {1'b0, sum}, {1'b0, es});
      check({nm, "_cout"}, 65'(cout), 65'(ec));
      check({nm, "_lat"}, 65'(lat), 65'd5);
      check({nm, "_busy_cycles"}, 65'(nb), 65'd4);
    end
  endtask

  initial begin
    logic [63:0] x;
    logic [63:0] y;
    logic        c;
    logic [64:0] r;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy", 65'(busy), 65'd0);
    check("reset_done", 65'(done), 65'd0);
    check("reset_sum", {1'b0, sum}, 65'd0);
    check("reset_cout", 65'(cout), 65'd0);
    #1 rst_n = 1'b1;

    run_add(64'd0, 64'd0, 1'b0, 64'd0, 1'b0, "zero");
    run_add(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, "carry_all");
    run_add(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, "s0_s1");
    run_add(64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1, 64'h0000_0001_0000_0000, 1'b0, "s1_s2");
    run_add(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
            64'h2222_2222_2222_2211, 1'b0, "mixed");
    run_add(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "max");

    // start held high with operands changing every cycle
    @(posedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      cin = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (8) @(posedge clk);

    // reset two edges after an accepted start aborts the add
    #1;
    a = 64'hDEAD_BEEF_0000_0001; b = 64'h1; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_busy", 65'(busy), 65'd0);
    check("abort_sum", {1'b0, sum}, 65'd0);
    check("abort_cout", 65'(cout), 65'd0);
    repeat (6) @(negedge clk);
    run_add(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
            64'h0001_0000_0001_0000, 1'b0, "after_abort");

    // random operands with random idle gaps
    for (int i = 0; i < 2000; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      c = 1'($urandom);
      r = {1'b0, x} + {1'b0, y} + 65'(c);
      run_add(x, y, c, r[63:0], r[64], "rand");
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
